// File: rtl/uart_str_tx.sv
// UART string transmitter: sends len bytes from a loadable buffer, plus an optional newline,
// as paced rib-bus writes to the UART TX data register.
module uart_str_tx #(
    parameter int          DEPTH   = 16,
    parameter int          AW      = 4,
    parameter int          LW      = 5,
    parameter int unsigned DIV     = 3520,
    parameter logic [31:0] TX_ADDR = 32'h3000_000C
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [LW-1:0] len_i,
    input  logic          nl_i,
    input  logic          abort_i,
    input  logic          load_we_i,
    input  logic [AW-1:0] load_idx_i,
    input  logic [7:0]    load_byte_i,
    input  logic          mem_ack_i,
    output logic          ready_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          mem_we_o,
    output logic [31:0]   mem_waddr_o,
    output logic [31:0]   mem_wdata_o
);

    typedef enum logic [1:0] {IDLE, WRITE, WAIT, DONE} state_t;

    localparam logic [31:0] CNT_LAST = 32'(DIV - 1);

    state_t        state_q;
    logic [AW-1:0] idx_q;
    logic [LW-1:0] len_q;
    logic          nl_q;
    logic          nlph_q;
    logic [31:0]   cnt_q;
    logic [7:0]    buf_q [DEPTH];

    logic [LW-1:0] len_clip_d;
    logic [7:0]    byte0_d;
    logic [AW-1:0] idx_d;
    logic          more_d;

    assign len_clip_d = (len_i > LW'(DEPTH)) ? LW'(DEPTH) : len_i;
    // A load landing on the start edge must be visible in the first byte sent.
    assign byte0_d    = (load_we_i && load_idx_i == '0) ? load_byte_i : buf_q[0];
    assign idx_d      = idx_q + AW'(1);
    assign more_d     = (LW'(idx_q) + LW'(1)) < len_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            nl_q        <= 1'b0;
            nlph_q      <= 1'b0;
            cnt_q       <= '0;
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= 8'h00;
            ready_o     <= 1'b1;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_waddr_o <= '0;
            mem_wdata_o <= '0;
        end else begin
            done_o <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (load_we_i) buf_q[load_idx_i] <= load_byte_i;
                    if (start_i) begin
                        len_q   <= len_clip_d;
                        nl_q    <= nl_i;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        // Zero-length start goes straight to the newline phase (or finishes).
                        nlph_q  <= (len_clip_d == '0);
                        ready_o <= 1'b0;
                        busy_o  <= 1'b1;
                        if (len_clip_d != '0 || nl_i) begin
                            state_q     <= WRITE;
                            mem_we_o    <= 1'b1;
                            mem_waddr_o <= TX_ADDR;
                            mem_wdata_o <= {24'h0, (len_clip_d != '0) ? byte0_d : 8'h0A};
                        end else begin
                            state_q <= DONE;
                            done_o  <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (abort_i || mem_ack_i) begin
                        mem_we_o    <= 1'b0;
                        mem_waddr_o <= '0;
                        mem_wdata_o <= '0;
                        cnt_q       <= '0;
                        if (abort_i) begin
                            state_q <= DONE;
                            done_o  <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (abort_i) begin
                        state_q <= DONE;
                        done_o  <= 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        if (!nlph_q && more_d) begin
                            idx_q       <= idx_d;
                            state_q     <= WRITE;
                            mem_we_o    <= 1'b1;
                            mem_waddr_o <= TX_ADDR;
                            mem_wdata_o <= {24'h0, buf_q[idx_d]};
                        end else if (nl_q && !nlph_q) begin
                            nlph_q      <= 1'b1;
                            state_q     <= WRITE;
                            mem_we_o    <= 1'b1;
                            mem_waddr_o <= TX_ADDR;
                            mem_wdata_o <= 32'h0000_000A;
                        end else begin
                            state_q <= DONE;
                            done_o  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_o <= 1'b1;
                    busy_o  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_str_tx.sv
// Randomised bench for uart_str_tx: a byte-list reference model predicts the bus writes and done latency.
module tb_uart_str_tx;

    localparam int          DIV = 4;
    localparam logic [31:0] TXA = 32'h3000_000C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [4:0]  len_i = '0;
    logic        nl_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        load_we_i = 1'b0;
    logic [3:0]  load_idx_i = '0;
    logic [7:0]  load_byte_i = '0;
    logic        mem_ack_i = 1'b1;
    logic        ready_o, busy_o, done_o, mem_we_o;
    logic [31:0] mem_waddr_o, mem_wdata_o;

    uart_str_tx #(.DEPTH(16), .AW(4), .LW(5), .DIV(DIV), .TX_ADDR(TXA)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .len_i(len_i), .nl_i(nl_i),
        .abort_i(abort_i), .load_we_i(load_we_i), .load_idx_i(load_idx_i),
        .load_byte_i(load_byte_i), .mem_ack_i(mem_ack_i), .ready_o(ready_o),
        .busy_o(busy_o), .done_o(done_o), .mem_we_o(mem_we_o),
        .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  mbuf [16];
    logic [7:0]  exp_q [$];
    logic [63:0] wr_q [$];
    time         wt_q [$];
    time         t0;

    // Accepted writes: enable and ack both high just before the rising edge.
    always @(negedge clk) begin
        if (rst && mem_we_o && mem_ack_i) begin
            wr_q.push_back({mem_waddr_o, mem_wdata_o});
            wt_q.push_back($time);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input logic [7:0] b);
        load_we_i   = 1'b1;
        load_idx_i  = idx[3:0];
        load_byte_i = b;
        tick();
        load_we_i   = 1'b0;
        mbuf[idx]   = b;
    endtask

    task automatic start(input int len, input bit nl, input bit ld = 1'b0,
                         input int ld_idx = 0, input logic [7:0] ld_b = 8'h00);
        if (ld) begin
            load_we_i   = 1'b1;
            load_idx_i  = ld_idx[3:0];
            load_byte_i = ld_b;
            mbuf[ld_idx] = ld_b;
        end
        exp_q.delete();
        for (int i = 0; i < ((len > 16) ? 16 : len); i++) exp_q.push_back(mbuf[i]);
        if (nl) exp_q.push_back(8'h0A);
        start_i = 1'b1;
        len_i   = len[4:0];
        nl_i    = nl;
        @(posedge clk);
        t0 = $time;
        #1;
        start_i   = 1'b0;
        load_we_i = 1'b0;
    endtask

    task automatic finish_xfer(input string tag, input int k_exp, input bit chk_gap = 1'b0);
        bit found = 1'b0;
        for (int i = 0; i < k_exp + 30; i++) begin
            @(negedge clk);
            if (done_o) begin
                found = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, 64'(found), 64'd1);
        if (found) begin
            chk({tag, "_latency"}, 64'(($time - t0 - 5) / 10), 64'(k_exp));
            chk({tag, "_busy_in_done"}, {ready_o, busy_o}, 64'b01);
            @(negedge clk);
            chk({tag, "_idle_after"}, {ready_o, busy_o, done_o, mem_we_o}, 64'b1000);
        end
        chk({tag, "_nwrites"}, 64'(wr_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
            chk({tag, "_addr"}, 64'(wr_q[i][63:32]), 64'(TXA));
            chk({tag, "_data"}, 64'(wr_q[i][31:0]), 64'(exp_q[i]));
            if (chk_gap && i > 0) chk({tag, "_gap"}, 64'(wt_q[i] - wt_q[i-1]), 64'(10 * (1 + DIV)));
        end
        wr_q.delete();
        wt_q.delete();
    endtask

    initial begin
        logic [7:0] id_str [10];
        logic [7:0] cap_d;
        logic [31:0] cap_a;
        int len;
        bit nl;
        id_str = '{8'h32, 8'h30, 8'h32, 8'h33, 8'h33, 8'h31, 8'h30, 8'h36, 8'h35, 8'h35};
        for (int i = 0; i < 16; i++) mbuf[i] = 8'h00;

        #1 rst = 1'b0;
        #7;
        chk("rst_outputs", {ready_o, busy_o, done_o, mem_we_o}, 64'b1000);
        chk("rst_bus", {mem_waddr_o, mem_wdata_o}, 64'h0);
        @(posedge clk); #1 rst = 1'b1;
        tick();

        // Student-ID string; a load while busy must not disturb the buffer.
        for (int i = 0; i < 10; i++) load(i, id_str[i]);
        start(10, 1'b0);
        load_we_i = 1'b1; load_idx_i = 4'd0; load_byte_i = 8'hEE;
        tick();
        load_we_i = 1'b0;
        finish_xfer("id", 10 * (1 + DIV), 1'b1);
        start(1, 1'b0);
        finish_xfer("busy_load", 1 + DIV);

        load(0, 8'h4F);
        load(1, 8'h4B);
        start(2, 1'b1);
        finish_xfer("ok_nl", 3 * (1 + DIV));

        start(0, 1'b0);
        finish_xfer("len0", 0);
        start(0, 1'b1);
        finish_xfer("len0_nl", 1 + DIV);
        start(20, 1'b0);
        finish_xfer("clip", 16 * (1 + DIV));

        // Three-cycle ack stall on byte 1.
        start(3, 1'b0);
        for (int i = 0; i < 40 && !(wr_q.size() == 1 && !mem_we_o); i++) @(negedge clk);
        tick();
        mem_ack_i = 1'b0;
        for (int i = 0; i < 40 && !mem_we_o; i++) @(negedge clk);
        cap_a = mem_waddr_o;
        cap_d = mem_wdata_o[7:0];
        chk("stall_data", 64'(cap_d), 64'(mbuf[1]));
        for (int s = 0; s < 2; s++) begin
            tick();
            @(negedge clk);
            chk("stall_hold", {mem_we_o, mem_waddr_o, mem_wdata_o[7:0]}, {1'b1, cap_a, cap_d});
        end
        tick();
        mem_ack_i = 1'b1;
        finish_xfer("stall", 3 * (1 + DIV) + 3);

        // Abort in WAIT after two bytes.
        start(5, 1'b0);
        for (int i = 0; i < 40 && !(wr_q.size() == 2 && !mem_we_o); i++) @(negedge clk);
        tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        while (exp_q.size() > 2) void'(exp_q.pop_back());
        finish_xfer("abort_wait", 8);

        // Abort coincident with ack: that byte counts, nothing else goes out.
        mem_ack_i = 1'b0;
        start(5, 1'b0);
        mem_ack_i = 1'b1;
        abort_i   = 1'b1;
        tick();
        abort_i = 1'b0;
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        finish_xfer("abort_ack", 1);

        // Random transfers, some with a load coincident with start.
        for (int r = 0; r < 8; r++) begin
            for (int j = 0; j < 3; j++) load($urandom_range(0, 15), 8'($urandom));
            len = $urandom_range(0, 20);
            nl  = 1'($urandom);
            start(len, nl, 1'($urandom), 0, 8'($urandom));
            finish_xfer("rand", (((len > 16) ? 16 : len) + int'(nl)) * (1 + DIV));
        end

        // Asynchronous reset in WAIT: immediate idle outputs, buffer cleared.
        start(4, 1'b0);
        for (int i = 0; i < 40 && !(wr_q.size() == 1 && !mem_we_o); i++) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_outputs", {ready_o, busy_o, done_o, mem_we_o}, 64'b1000);
        chk("midrst_bus", {mem_waddr_o, mem_wdata_o}, 64'h0);
        @(posedge clk); #1 rst = 1'b1;
        for (int i = 0; i < 16; i++) mbuf[i] = 8'h00;
        wr_q.delete();
        wt_q.delete();
        tick();
        start(2, 1'b0);
        finish_xfer("after_rst", 2 * (1 + DIV));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
